// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer for the iterative RV32M divider (DIV/DIVU/REM/REMU).
// Accepts one op from EX, runs a radix-2 restoring divide over XLEN cycles
// while stalling the pipeline, and returns the result with its rd. Divide by
// zero and signed overflow are resolved at accept and finish a cycle later.
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out,
  output logic            wb_en_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // Registered state
  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              rem_sel_q, rem_sel_d;

  // Operand decode at accept time
  logic              is_signed;
  logic              s1, s2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, ovf, special;
  logic              can_take, accept;
  logic [XLEN-1:0]   special_res;

  // One restoring-divide step
  logic [XLEN-1:0]   rem_shift, rem_trial;
  logic              fits;

  // Sign fix-up of the finished magnitudes
  logic [XLEN-1:0]   q_fin, r_fin;

  // Decode the incoming op: magnitudes, signs and the two one-cycle cases.
  always_comb begin
    is_signed   = ~op[0];
    s1          = is_signed & rs1_data[XLEN-1];
    s2          = is_signed & rs2_data[XLEN-1];
    abs1        = s1 ? (-rs1_data) : rs1_data;
    abs2        = s2 ? (-rs2_data) : rs2_data;
    div_zero    = (rs2_data == '0);
    ovf         = is_signed && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
    special     = div_zero | ovf;
    can_take    = (state_q == S_IDLE) || (state_q == S_DONE);
    accept      = can_take && start && !flush;
    special_res = '0;
    if (op[1]) begin
      special_res = div_zero ? rs1_data : '0;
    end else begin
      special_res = div_zero ? ALL_ONES : MIN_NEG;
    end
  end

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The remainder is always below the divisor, so a set top bit means the
  // shifted value has overflowed XLEN bits and certainly fits.
  always_comb begin
    rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    fits      = rem_q[XLEN-1] | (rem_shift >= dvsr_q);
    rem_trial = rem_shift - dvsr_q;
    q_fin     = q_neg_q ? (-quo_q) : quo_q;
    r_fin     = r_neg_q ? (-rem_q) : rem_q;
  end

  // Freeze the front of the pipeline for an accepted multi-cycle op and
  // for as long as the divider is iterating or fixing signs.
  always_comb begin
    stall = (accept && !special) || (state_q == S_RUN) || (state_q == S_FIX);
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          rem_sel_d = op[1];
          rd_d      = rd_addr_in;
          if (special) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res;
            rd_out_d = rd_addr_in;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(XLEN);
            quo_d   = abs1;
            rem_d   = '0;
            dvsr_d  = abs2;
            q_neg_d = (s1 ^ s2) & ~div_zero;
            r_neg_d = s1;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          quo_d  = {quo_q[XLEN-2:0], fits};
          rem_d  = fits ? rem_trial : rem_shift;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = rem_sel_q ? r_fin : q_fin;
          rd_out_d = rd_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign rd_addr_out = rd_out_q;
  assign wb_en_out   = done_q && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and random checks of the divide sequencer
// against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic            flush;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic [4:0]      rdIn;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rdOut;
  logic            wbEn;

  int nAssert = 0;
  int nFail   = 0;

  logic [31:0] expResult;
  logic [4:0]  expRd;
  int          expLatency;
  int          stallCount;
  int          doneCycle;
  logic [31:0] prevResult;

  div_seq_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .flush      (flush),
    .rs1_data   (rs1Data),
    .rs2_data   (rs2Data),
    .rd_addr_in (rdIn),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_addr_out(rdOut),
    .wb_en_out  (wbEn)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Architectural RV32M divide result, special cases first.
  function automatic logic [31:0] refModel(input logic [1:0] fOp, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return fOp[1] ? a : 32'hFFFF_FFFF;
    if (!fOp[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return fOp[1] ? 32'h0 : 32'h8000_0000;
    if (fOp[0]) return fOp[1] ? (a % b) : (a / b);
    return fOp[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit isSpecial(input logic [1:0] fOp, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!fOp[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an op at the current (negedge) time and check the accept-cycle stall.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    bit sp;
    sp         = isSpecial(o, a, b);
    start      = 1'b1;
    op         = o;
    rs1Data    = a;
    rs2Data    = b;
    rdIn       = r;
    expResult  = refModel(o, a, b);
    expRd      = r;
    expLatency = sp ? 1 : XLEN + 2;
    #1;
    checkOutput("stall_at_accept", {31'b0, stall}, {31'b0, !sp});
    stallCount = stall ? 1 : 0;
  endtask

  // Release start after the accept edge, then wait (bounded) for done.
  task automatic waitForDone(input string tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    doneCycle = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (stall) stallCount++;
      if (done) begin
        doneCycle = cyc;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(doneCycle), 32'(expLatency));
    checkOutput({tag, "_stall_cycles"}, 32'(stallCount), (expLatency == 1) ? 32'd0 : 32'(XLEN + 2));
    checkOutput({tag, "_result"}, result, expResult);
    checkOutput({tag, "_rd"}, {27'b0, rdOut}, {27'b0, expRd});
    checkOutput({tag, "_wb_en"}, {31'b0, wbEn}, {31'b0, (doneCycle != 0) && (expRd != 5'd0)});
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r, input string tag);
    @(negedge clk);
    applyStimulus(o, a, b, r);
    waitForDone(tag);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_stall"}, {31'b0, stall}, 32'd0);
  endtask

  // Linear sequence of directed scenarios followed by random ops.
  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    op      = 2'b00;
    rs1Data = '0;
    rs2Data = '0;
    rdIn    = '0;
    #12;
    checkIdleOutputs("reset");
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_rd", {27'b0, rdOut}, 32'd0);
    checkOutput("reset_wb_en", {31'b0, wbEn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] DIV 100/7");
    runOp(2'b00, 32'd100, 32'd7, 5'd5, "div_100_7");
    checkOutput("div_100_7_value", result, 32'd14);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
    checkOutput("result_holds", result, 32'd14);

    $display("[TB] signed and unsigned remainder");
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_m7_2");
    checkOutput("rem_m7_2_value", result, 32'hFFFF_FFFF);
    runOp(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6, "remu_m7_2");
    checkOutput("remu_m7_2_value", result, 32'd1);

    $display("[TB] divide by zero and overflow");
    runOp(2'b01, 32'd5, 32'd0, 5'd1, "divu_5_0");
    checkOutput("divu_5_0_value", result, 32'hFFFF_FFFF);
    runOp(2'b10, 32'd5, 32'd0, 5'd1, "rem_5_0");
    checkOutput("rem_5_0_value", result, 32'd5);
    runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, "div_ovf");
    checkOutput("div_ovf_value", result, 32'h8000_0000);
    checkOutput("div_ovf_no_busy", {31'b0, busy}, 32'd0);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, "rem_ovf");
    checkOutput("rem_ovf_value", result, 32'd0);

    $display("[TB] flush during RUN");
    prevResult = result;
    @(negedge clk);
    applyStimulus(2'b00, 32'd1000, 32'd3, 5'd4);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkIdleOutputs("after_flush");
    repeat (3) begin
      @(negedge clk);
      checkOutput("flush_no_done", {31'b0, done}, 32'd0);
    end
    checkOutput("flush_result_holds", result, prevResult);
    runOp(2'b01, 32'd9, 32'd3, 5'd7, "divu_9_3");
    checkOutput("divu_9_3_value", result, 32'd3);

    $display("[TB] flush together with start");
    @(negedge clk);
    start   = 1'b1;
    flush   = 1'b1;
    op      = 2'b01;
    rs1Data = 32'd50;
    rs2Data = 32'd5;
    rdIn    = 5'd9;
    #1;
    checkOutput("flush_start_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    checkIdleOutputs("flush_start");

    $display("[TB] reset mid-operation");
    @(negedge clk);
    applyStimulus(2'b01, 32'd12345, 32'd11, 5'd9);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("mid_reset");
    checkOutput("mid_reset_result", result, 32'd0);
    checkOutput("mid_reset_rd", {27'b0, rdOut}, 32'd0);
    checkOutput("mid_reset_wb_en", {31'b0, wbEn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] back-to-back ops");
    runOp(2'b01, 32'd50, 32'd5, 5'd3, "b2b_first");
    applyStimulus(2'b00, 32'hFFFF_FFEC, 32'd3, 5'd0);
    waitForDone("b2b_second");
    checkOutput("b2b_second_value", result, 32'hFFFF_FFFA);
    applyStimulus(2'b01, 32'd1, 32'd0, 5'd8);
    waitForDone("b2b_special");

    $display("[TB] random ops");
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rOp;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  r;
      int          pick;
      rOp  = 2'($urandom_range(0, 3));
      r    = 5'($urandom_range(0, 31));
      pick = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      if (pick == 0) b = 32'd0;
      else if (pick == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (pick == 2) begin
        a = 32'($urandom_range(0, 1000));
        b = 32'($urandom_range(1, 40));
      end else if (pick == 3) b = 32'($urandom_range(1, 9)) | (b & 32'h8000_0000);
      runOp(rOp, a, b, r, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
